// File: rtl/uart_tx_ctrl_pkg.sv
// Shared UART definitions: FSM state encoding, TX output-mux codes and parity types.
package uart_tx_ctrl_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      START  = ST_START,
      DATA   = ST_DATA,
      PARITY = ST_PARITY,
      STOP   = ST_STOP
   } tx_state_e;

   localparam logic [1:0] MUX_START = 2'b00;
   localparam logic [1:0] MUX_STOP  = 2'b01;
   localparam logic [1:0] MUX_DATA  = 2'b10;
   localparam logic [1:0] MUX_PAR   = 2'b11;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl_parity_calc.sv
// Combinational parity generator, shared between the TX controller and the RX checker.
module parity_calc
   import uart_tx_ctrl_pkg::*;
#(
   parameter int Data_Width = 8
) (
   input  logic [Data_Width-1:0] data_i,
   input  logic                  typ_i,
   output logic                  par_o
);

   // Even parity: bit makes the total count of ones even; odd type inverts it.
   assign par_o = (^data_i) ^ (typ_i == PAR_ODD);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: latches a byte with its parity bit and sequences
// start, data, optional parity and stop bits through the serializer and output mux.
module uart_tx_ctrl
   import uart_tx_ctrl_pkg::*;
#(
   parameter int Data_Width = 8
) (
   input  logic                  clk,
   input  logic                  RST,
   input  logic [Data_Width-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  ser_done,
   output logic                  ser_en,
   output logic [Data_Width-1:0] ser_data,
   output logic                  par_bit,
   output logic [1:0]            mux_sel,
   output logic                  busy
);

   tx_state_e             state_q, state_d;
   logic [Data_Width-1:0] ser_data_q;
   logic                  par_bit_q;
   logic                  par_en_q;
   logic                  par_calc;
   logic                  accept;

   parity_calc #(.Data_Width(Data_Width)) u_parity (
      .data_i (P_DATA),
      .typ_i  (PAR_TYP),
      .par_o  (par_calc)
   );

   // New data is only taken when no frame is on the wire, or in STOP for back-to-back.
   assign accept = Data_Valid && ((state_q == IDLE) || (state_q == STOP));

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q    <= IDLE;
         ser_data_q <= '0;
         par_bit_q  <= 1'b0;
         par_en_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            ser_data_q <= P_DATA;
            par_bit_q  <= par_calc;
            par_en_q   <= PAR_EN;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      mux_sel = MUX_STOP;
      ser_en  = 1'b0;
      busy    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) state_d = START;
         end
         START: begin
            mux_sel = MUX_START;
            busy    = 1'b1;
            state_d = DATA;
         end
         DATA: begin
            mux_sel = MUX_DATA;
            ser_en  = 1'b1;
            busy    = 1'b1;
            if (ser_done) state_d = par_en_q ? PARITY : STOP;
         end
         PARITY: begin
            mux_sel = MUX_PAR;
            busy    = 1'b1;
            state_d = STOP;
         end
         STOP: begin
            busy    = 1'b1;
            state_d = accept ? START : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign ser_data = ser_data_q;
   assign par_bit  = par_bit_q;

endmodule
